// File: rtl/switch_input_pkg.sv
// Shared definitions for the debounced switch input controller:
// register map, CTRL bit positions and a constant-width helper.
package switch_input_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,
        ADDR_CTRL = 2'd1,
        ADDR_MASK = 2'd2,
        ADDR_EDGE = 2'd3
    } reg_addr_e;

    localparam int unsigned CTRL_EN_BIT = 0;

    // Bits needed to hold values 0..value-1 (value >= 2).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch bit: 2-FF synchroniser followed by a tick-sampled debouncer
// that accepts a new level once it has been seen on STABLE_TICKS ticks in a row.
module switch_debounce_bit
    import switch_input_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic raw,
    output logic deb
);

    localparam int unsigned   CW       = clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            cnt  <= '0;
            deb  <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
            // A matching sample restarts the count; the final mismatching tick flips deb.
            if (tick) begin
                if (sync == deb) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    deb <= ~deb;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/switch_input_ctrl.sv
// Avalon-MM switch input controller: debounced DATA, CTRL enable, MASK and W1C EDGE
// registers with a level irq. Define SWITCH_INPUT_CTRL_BOTH_EDGES_EN to capture falling edges too.
module switch_input_ctrl
    import switch_input_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned TICK_CYCLES  = 50000,
    parameter int unsigned STABLE_TICKS = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int unsigned   PW       = clog2(TICK_CYCLES);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);

    logic             tick;
    logic [PW-1:0]    pre_cnt;
    logic             en;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_q;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] edge_r;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] w1c;
    logic             wr_en;
    logic             wr_ctrl;
    logic             wr_mask;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign wr_en   = chipselect && !write_n;
    assign wr_ctrl = wr_en && (reg_addr_e'(address) == ADDR_CTRL);
    assign wr_mask = wr_en && (reg_addr_e'(address) == ADDR_MASK);
    assign w1c     = (wr_en && (reg_addr_e'(address) == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;
    assign tick    = en && (pre_cnt == PRE_LAST);
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
        end else if (en) begin
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PW'(1);
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        switch_debounce_bit #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_deb (
            .clk     (clk),
            .reset_n (reset_n),
            .tick    (tick),
            .raw     (in_port[gi]),
            .deb     (deb[gi])
        );
    end

`ifdef SWITCH_INPUT_CTRL_BOTH_EDGES_EN
    assign edge_evt = deb ^ deb_q;
`else
    assign edge_evt = deb & ~deb_q;
`endif

    always_comb begin
        rd_mux = '0;
        case (reg_addr_e'(address))
            ADDR_DATA: rd_mux[WIDTH-1:0]   = deb;
            ADDR_CTRL: rd_mux[CTRL_EN_BIT] = en;
            ADDR_MASK: rd_mux[WIDTH-1:0]   = mask_r;
            ADDR_EDGE: rd_mux[WIDTH-1:0]   = edge_r;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en       <= 1'b0;
            mask_r   <= '0;
            edge_r   <= '0;
            deb_q    <= '0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            if (wr_ctrl) en <= writedata[CTRL_EN_BIT];
            if (wr_mask) mask_r <= writedata[WIDTH-1:0];
            // OR-ing the event after the clear lets a coincident edge win over W1C.
            edge_r   <= (edge_r & ~w1c) | edge_evt;
            deb_q    <= deb;
            irq      <= |(edge_r & mask_r);
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_switch_input_ctrl.sv
// Self-checking bench for switch_input_ctrl against a cycle-level behavioural model.
module tb_switch_input_ctrl;

    localparam int TICK_CYCLES  = 4;
    localparam int STABLE_TICKS = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [7:0]  in_port = 8'h00;
    logic        irq;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [7:0]  raw_hist [2];
    int          m_run [8];
    int          m_en_cycles;
    logic        m_en;
    logic [7:0]  m_deb, m_debq, m_mask, m_edge;
    logic        m_irq;
    logic [31:0] m_rd;

    switch_input_ctrl #(
        .WIDTH        (8),
        .TICK_CYCLES  (TICK_CYCLES),
        .STABLE_TICKS (STABLE_TICKS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        raw_hist[0] = 8'h00;
        raw_hist[1] = 8'h00;
        for (int i = 0; i < 8; i++) m_run[i] = 0;
        m_en_cycles = 0;
        m_en = 1'b0;
        m_deb = 8'h00; m_debq = 8'h00; m_mask = 8'h00; m_edge = 8'h00;
        m_irq = 1'b0;
        m_rd = 32'd0;
    endtask

    // Advance the model across one rising edge using the inputs presented to it.
    task automatic model_step();
        logic [7:0]  sync_now, deb_new, evt, wmask;
        logic [31:0] rd_new;
        logic        tick_now, wr_en;
        if (!reset_n) begin
            model_reset();
            return;
        end
        wr_en    = chipselect && !write_n;
        tick_now = m_en && ((m_en_cycles % TICK_CYCLES) == TICK_CYCLES - 1);
        sync_now = raw_hist[1];
        deb_new  = m_deb;
        if (tick_now) begin
            for (int i = 0; i < 8; i++) begin
                if (sync_now[i] != m_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == STABLE_TICKS) begin
                        deb_new[i] = ~m_deb[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
`ifdef SWITCH_INPUT_CTRL_BOTH_EDGES_EN
        evt = m_deb ^ m_debq;
`else
        evt = m_deb & ~m_debq;
`endif
        case (address)
            2'd0:    rd_new = {24'd0, m_deb};
            2'd1:    rd_new = {31'd0, m_en};
            2'd2:    rd_new = {24'd0, m_mask};
            default: rd_new = {24'd0, m_edge};
        endcase
        wmask  = (wr_en && address == 2'd3) ? writedata[7:0] : 8'h00;
        m_irq  = |(m_edge & m_mask);
        m_rd   = rd_new;
        m_edge = (m_edge & ~wmask) | evt;
        if (wr_en && address == 2'd2) m_mask = writedata[7:0];
        if (m_en) m_en_cycles++;
        if (wr_en && address == 2'd1) m_en = writedata[0];
        m_debq = m_deb;
        m_deb  = deb_new;
        raw_hist[1] = raw_hist[0];
        raw_hist[0] = in_port;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            chk("readdata", readdata, m_rd);
            chk("irq", {31'd0, irq}, {31'd0, m_irq});
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        cyc(1);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        int  n;
        logic seen;
        model_reset();
        cyc(3);
        reset_n = 1'b1;

        // Reset state and disabled sampling
        in_port = 8'hFF;
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            cyc(1);
            chk("reset_read", readdata, 32'd0);
        end
        address = 2'd0;
        cyc(6);
        chk("data_while_disabled", readdata, 32'd0);

        // Clean change and its latency window
        in_port = 8'h00;
        cyc(3);
        wr(2'd1, 32'd1);
        cyc(20);
        address = 2'd0;
        in_port = 8'h05;
        n = 0;
        seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            cyc(1);
            if (readdata === 32'h5) begin seen = 1'b1; n = i; end
        end
        chk("clean_latency_window", {31'd0, seen && n >= 12 && n <= 15}, 32'd1);
        address = 2'd3;
        cyc(1);
        chk("edge_after_clean", readdata, 32'h5);
        chk("irq_masked", {31'd0, irq}, 32'd0);

        // Bounce on bit0
        wr(2'd3, 32'hFF);
        in_port = 8'h04;
        cyc(25);
        wr(2'd3, 32'hFF);
        address = 2'd0;
        seen = 1'b0;
        for (int t = 0; t < 40; t++) begin
            in_port = {7'b0000010, ((t / 3) % 2 == 0)};
            cyc(1);
            seen = seen | readdata[0];
        end
        chk("bit0_held_during_bounce", {31'd0, seen}, 32'd0);
        in_port = 8'h05;
        seen = 1'b0;
        for (int i = 1; i <= 15 && !seen; i++) begin
            cyc(1);
            if (readdata[0] === 1'b1) seen = 1'b1;
        end
        chk("settle_within_bound", {31'd0, seen}, 32'd1);
        address = 2'd3;
        cyc(5);
        chk("single_edge_bit0", readdata, 32'h1);

        // Masked interrupt, W1C and set-beats-clear
        wr(2'd2, 32'h01);
        wr(2'd3, 32'hFF);
        in_port = 8'h04;
        cyc(20);
        wr(2'd3, 32'hFF);
        cyc(2);
        in_port = 8'h05;
        address = 2'd3;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc(1);
            if (readdata[0] === 1'b1) seen = 1'b1;
        end
        chk("edge0_set", {31'd0, seen}, 32'd1);
        chk("irq_follows_edge", {31'd0, irq}, 32'd1);
        wr(2'd3, 32'h01);
        cyc(1);
        chk("irq_cleared", {31'd0, irq}, 32'd0);
        in_port = 8'h04;
        cyc(20);
        wr(2'd3, 32'hFF);
        in_port = 8'h05;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc(1);
            if (m_deb[0] && !m_debq[0]) seen = 1'b1;
        end
        chk("rise_found", {31'd0, seen}, 32'd1);
        wr(2'd3, 32'h01);
        address = 2'd3;
        cyc(1);
        chk("set_beats_clear", {31'd0, readdata[0]}, 32'd1);
        wr(2'd3, 32'hFF);
        wr(2'd2, 32'h00);

        // Enable dropped mid-count
        in_port = 8'h07;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc(1);
            if (m_run[1] == 2) seen = 1'b1;
        end
        chk("two_ticks_reached", {31'd0, seen}, 32'd1);
        wr(2'd1, 32'd0);
        address = 2'd0;
        cyc(100);
        chk("data_held_disabled", readdata, 32'h5);
        wr(2'd1, 32'd1);
        address = 2'd0;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            cyc(1);
            if (readdata === 32'h7) seen = 1'b1;
        end
        chk("resume_within_tick", {31'd0, seen}, 32'd1);

        // Asynchronous reset pulse
        wr(2'd2, 32'hFF);
        address = 2'd0;
        cyc(2);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_readdata", readdata, 32'd0);
        chk("async_reset_irq", {31'd0, irq}, 32'd0);
        model_reset();
        cyc(1);
        #2 reset_n = 1'b1;
        address = 2'd2;
        cyc(1);
        chk("mask_after_reset", readdata, 32'd0);
        wr(2'd1, 32'd1);
        address = 2'd3;
        cyc(25);
        chk("redebounce_edges", readdata, 32'h7);
        wr(2'd3, 32'hFF);
        in_port = 8'h05;
        cyc(20);
`ifdef SWITCH_INPUT_CTRL_BOTH_EDGES_EN
        chk("fall_edge", readdata, 32'h2);
`else
        chk("fall_edge", readdata, 32'h0);
`endif

        // Randomised traffic
        for (int k = 0; k < 2000; k++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3) in_port = 8'($urandom);
            else if (r < 8) in_port[$urandom_range(0, 7)] = ~in_port[$urandom_range(0, 7)];
            address = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) begin
                chipselect = 1'($urandom_range(0, 3) != 0);
                write_n    = 1'($urandom_range(0, 1));
                writedata  = $urandom;
                if (address == 2'd1) writedata[0] = ($urandom_range(0, 7) != 0);
            end
            cyc(1);
            chipselect = 1'b0;
            write_n = 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
